irrigation_scheduler: RTL



---
 rtl/irrigation_pkg.sv | 29 ++
 rtl/irrigation_scheduler_timer.sv | 47 ++++
 rtl/irrigation_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/irrigation_pkg.sv
// Shared codes for the irrigation scheduler and the irrigation-mode FSM:
// soil-moisture codes, request-bus codes and the scheduler state encoding.
package irrigation_pkg;

    // Soil-moisture sensor codes
    localparam logic [1:0] WET    = 2'b00;
    localparam logic [1:0] DRY    = 2'b01;
    localparam logic [1:0] VDRY   = 2'b10;
    localparam logic [1:0] SFAULT = 2'b11;

    // Request codes on the rega bus (bit1 sprinkler, bit0 drip)
    localparam logic [1:0] NADA = 2'b00;
    localparam logic [1:0] GOT  = 2'b01;
    localparam logic [1:0] ASP  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_RUN   = 3'd2,
        S_COOL  = 3'd3,
        S_FAULT = 3'd4
    } sched_state_t;

    // Moisture codes that ask for irrigation map one-to-one onto rega codes
    function automatic logic is_request(input logic [1:0] m);
        return (m == DRY) || (m == VDRY);
    endfunction

endpackage

// File: rtl/irrigation_scheduler_timer.sv
// Shared cycle counter for the scheduler: synchronous clear and increment,
// with terminal compares for priming, minimum run, maximum run and cooldown.
module sched_timer #(
    parameter int unsigned PRIME_CYCLES = 4,
    parameter int unsigned MIN_RUN      = 8,
    parameter int unsigned MAX_RUN      = 32,
    parameter int unsigned COOLDOWN     = 3,
    parameter int unsigned CW           = 6
) (
    input  logic CLK,
    input  logic resetN,
    input  logic clr_i,
    input  logic inc_i,
    output logic prime_done_o,
    output logic min_met_o,
    output logic max_hit_o,
    output logic cool_done_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear has priority over increment; otherwise the count holds
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, asynchronously cleared
    always_ff @(posedge CLK or posedge resetN) begin
        if (resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign prime_done_o = (cnt_q == CW'(PRIME_CYCLES - 1));
    assign min_met_o    = (cnt_q >= CW'(MIN_RUN - 1));
    assign max_hit_o    = (cnt_q == CW'(MAX_RUN - 1));
    assign cool_done_o  = (cnt_q == CW'(COOLDOWN - 1));

endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation sequencing controller: primes the pump, requests drip or
// sprinkler on rega, bounds run time, cools down, and locks out on a
// moisture-sensor fault. Outputs decode from registered state only.
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int unsigned PRIME_CYCLES = 4,
    parameter int unsigned MIN_RUN      = 8,
    parameter int unsigned MAX_RUN      = 32,
    parameter int unsigned COOLDOWN     = 3,
    parameter int unsigned CW           = 6
) (
    input  logic       CLK,
    input  logic       resetN,
    input  logic       enable,
    input  logic [1:0] moist,
    input  logic       water_ok,
    output logic [1:0] rega,
    output logic       pump_on,
    output logic       busy,
    output logic       fault
);

    sched_state_t state_q, state_d;
    logic [1:0]   mode_q, mode_d;
    logic         mode_switch;
    logic         timer_clr;
    logic         timer_inc;
    logic         prime_done, min_met, max_hit, cool_done;

    sched_timer #(
        .PRIME_CYCLES(PRIME_CYCLES),
        .MIN_RUN     (MIN_RUN),
        .MAX_RUN     (MAX_RUN),
        .COOLDOWN    (COOLDOWN),
        .CW          (CW)
    ) u_timer (
        .CLK         (CLK),
        .resetN      (resetN),
        .clr_i       (timer_clr),
        .inc_i       (timer_inc),
        .prime_done_o(prime_done),
        .min_met_o   (min_met),
        .max_hit_o   (max_hit),
        .cool_done_o (cool_done)
    );

    // State and latched mode registers, asynchronously reset to IDLE/none
    always_ff @(posedge CLK or posedge resetN) begin
        if (resetN) begin
            state_q <= S_IDLE;
            mode_q  <= NADA;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic plus Moore output decode from state_q/mode_q
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        mode_switch = 1'b0;
        rega        = NADA;
        pump_on     = 1'b0;
        busy        = 1'b0;
        fault       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (moist == SFAULT) begin
                    state_d = S_FAULT;
                end else if (enable && water_ok && is_request(moist)) begin
                    state_d = S_PRIME;
                    mode_d  = moist;
                end
            end

            S_PRIME: begin
                pump_on = 1'b1;
                busy    = 1'b1;
                if (moist == SFAULT) begin
                    state_d = S_FAULT;
                end else if (!water_ok) begin
                    state_d = S_COOL;
                end else if (prime_done) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                pump_on = 1'b1;
                busy    = 1'b1;
                rega    = mode_q;
                if (moist == SFAULT) begin
                    state_d = S_FAULT;
                end else if (!water_ok) begin
                    // Supply loss aborts at once, ignoring the minimum run
                    state_d = S_COOL;
                end else if (max_hit) begin
                    state_d = S_COOL;
                end else if (min_met && ((moist == WET) || !enable)) begin
                    state_d = S_COOL;
                end else if (min_met && is_request(moist) && (moist != mode_q)) begin
                    // Direct handover between drip and sprinkler, no idle gap
                    mode_d      = moist;
                    mode_switch = 1'b1;
                end
            end

            S_COOL: begin
                busy = 1'b1;
                if (moist == SFAULT) begin
                    state_d = S_FAULT;
                end else if (cool_done) begin
                    state_d = S_IDLE;
                end
            end

            S_FAULT: begin
                fault = 1'b1;
                // Operator must drop enable once the sensor has recovered
                if ((moist != SFAULT) && !enable) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign timer_clr = (state_d != state_q) || mode_switch;
    assign timer_inc = (state_q == S_PRIME) || (state_q == S_RUN) || (state_q == S_COOL);

endmodule
